// File: rtl/elevator_scheduler_pkg.sv
// Shared definitions for the elevator car scheduler: FSM state encoding,
// default geometry/timing constants and a small elaboration helper.
package elevator_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_ARRIVE = 2'd2,
        ST_DOOR   = 2'd3
    } state_t;

    localparam int DEF_NFLOOR   = 4;
    localparam int DEF_MOVE_CYC = 50_000_000;
    localparam int DEF_DOOR_CYC = 100_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_scheduler_timer.sv
// elev_timer: loadable down-counter that saturates at zero. One instance is
// time-shared by the floor-travel and door-open phases of the scheduler.
module elevator_scheduler_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN (collective) car-motion scheduler: latches hall/car calls, picks the
// travel direction, and sequences move / arrive / door phases with served strobes.
module elevator_scheduler
    import elevator_scheduler_pkg::*;
#(
    parameter int NFLOOR   = DEF_NFLOOR,
    parameter int FLOOR_W  = 2,
    parameter int MOVE_CYC = DEF_MOVE_CYC,
    parameter int DOOR_CYC = DEF_DOOR_CYC
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NFLOOR-1:0]  hall_up,
    input  logic [NFLOOR-1:0]  hall_dn,
    input  logic [NFLOOR-1:0]  car_call,
    input  logic               door_hold,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic [NFLOOR-1:0]  served_up,
    output logic [NFLOOR-1:0]  served_dn,
    output logic [NFLOOR-1:0]  served_car
);

    localparam int                  TIMER_W   = $clog2(max_int(MOVE_CYC, DOOR_CYC));
    localparam logic [TIMER_W-1:0]  MOVE_LOAD = TIMER_W'(MOVE_CYC - 1);
    localparam logic [TIMER_W-1:0]  DOOR_LOAD = TIMER_W'(DOOR_CYC - 1);
    localparam logic [FLOOR_W-1:0]  TOP       = FLOOR_W'(NFLOOR - 1);
    // No up call exists at the top floor and no down call at the bottom.
    localparam logic [NFLOOR-1:0]   UP_MASK   = ~(NFLOOR'(1) << (NFLOOR - 1));
    localparam logic [NFLOOR-1:0]   DN_MASK   = ~NFLOOR'(1);

    state_t              state_reg, state_next;
    logic [FLOOR_W-1:0]  floor_reg, floor_next;
    logic                dir_reg, dir_next;
    logic [NFLOOR-1:0]   pend_up_reg, pend_dn_reg, pend_car_reg;
    logic [NFLOOR-1:0]   pend_up_next, pend_dn_next, pend_car_next;
    logic [NFLOOR-1:0]   served_up_reg, served_dn_reg, served_car_reg;
    logic [NFLOOR-1:0]   srv_up_next, srv_dn_next, srv_car_next;
    logic                srv_up_bit, srv_dn_bit, srv_car_bit;

    logic [NFLOOR-1:0]   pend_any, above_vec, below_vec, here_vec;
    logic                above, below, here, beyond;
    logic                at_up, at_dn, at_car, stop, enter_door;

    logic                tmr_load, tmr_zero;
    logic [TIMER_W-1:0]  tmr_val;

    elevator_scheduler_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign pend_any = pend_up_reg | pend_dn_reg | pend_car_reg;

    for (genvar gi = 0; gi < NFLOOR; gi++) begin : g_floor
        assign above_vec[gi]    = pend_any[gi] && (gi > int'(floor_reg));
        assign below_vec[gi]    = pend_any[gi] && (gi < int'(floor_reg));
        assign here_vec[gi]     = pend_any[gi] && (gi == int'(floor_reg));
        assign srv_up_next[gi]  = srv_up_bit  && (gi == int'(floor_reg));
        assign srv_dn_next[gi]  = srv_dn_bit  && (gi == int'(floor_reg));
        assign srv_car_next[gi] = srv_car_bit && (gi == int'(floor_reg));
    end

    assign above  = |above_vec;
    assign below  = |below_vec;
    assign here   = |here_vec;
    assign beyond = dir_reg ? above : below;
    assign at_up  = pend_up_reg[floor_reg];
    assign at_dn  = pend_dn_reg[floor_reg];
    assign at_car = pend_car_reg[floor_reg];

    // A serve clears its bit even if the input is still high; it re-latches next cycle.
    assign pend_up_next  = (pend_up_reg  | (hall_up & UP_MASK)) & ~srv_up_next;
    assign pend_dn_next  = (pend_dn_reg  | (hall_dn & DN_MASK)) & ~srv_dn_next;
    assign pend_car_next = (pend_car_reg | car_call)            & ~srv_car_next;

    always_comb begin
        state_next  = state_reg;
        floor_next  = floor_reg;
        dir_next    = dir_reg;
        tmr_load    = 1'b0;
        tmr_val     = MOVE_LOAD;
        enter_door  = 1'b0;
        srv_up_bit  = 1'b0;
        srv_dn_bit  = 1'b0;
        srv_car_bit = 1'b0;
        stop        = at_car | (dir_reg ? at_up : at_dn) | (!beyond & (at_up | at_dn));

        case (state_reg)
            ST_IDLE: begin
                if (here) begin
                    enter_door = 1'b1;
                end else if (above && (dir_reg || !below)) begin
                    dir_next   = 1'b1;
                    tmr_load   = 1'b1;
                    state_next = ST_MOVE;
                end else if (below) begin
                    dir_next   = 1'b0;
                    tmr_load   = 1'b1;
                    state_next = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (tmr_zero) begin
                    state_next = ST_ARRIVE;
                    if (dir_reg && floor_reg != TOP) begin
                        floor_next = floor_reg + FLOOR_W'(1);
                    end else if (!dir_reg && floor_reg != '0) begin
                        floor_next = floor_reg - FLOOR_W'(1);
                    end
                end
            end
            ST_ARRIVE: begin
                // Nothing left ahead: park here rather than run past the shaft end.
                if (stop || !beyond) begin
                    enter_door = 1'b1;
                end else begin
                    tmr_load   = 1'b1;
                    state_next = ST_MOVE;
                end
            end
            ST_DOOR: begin
                srv_car_bit = at_car;
                srv_up_bit  = dir_reg & at_up;
                srv_dn_bit  = !dir_reg & at_dn;
                if (at_car || (dir_reg & at_up) || (!dir_reg & at_dn) || door_hold) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LOAD;
                end else if (tmr_zero) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (enter_door) begin
            state_next  = ST_DOOR;
            tmr_load    = 1'b1;
            tmr_val     = DOOR_LOAD;
            srv_car_bit = at_car;
            srv_up_bit  = at_up & (dir_reg | !beyond);
            srv_dn_bit  = at_dn & (!dir_reg | !beyond);
            // Reverse when the sweep is exhausted; at a shaft end the only sane direction is inward.
            if (!beyond) begin
                if (floor_reg == '0) begin
                    dir_next = 1'b1;
                end else if (floor_reg == TOP) begin
                    dir_next = 1'b0;
                end else begin
                    dir_next = !dir_reg;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= ST_IDLE;
            floor_reg      <= '0;
            dir_reg        <= 1'b1;
            pend_up_reg    <= '0;
            pend_dn_reg    <= '0;
            pend_car_reg   <= '0;
            served_up_reg  <= '0;
            served_dn_reg  <= '0;
            served_car_reg <= '0;
        end else begin
            state_reg      <= state_next;
            floor_reg      <= floor_next;
            dir_reg        <= dir_next;
            pend_up_reg    <= pend_up_next;
            pend_dn_reg    <= pend_dn_next;
            pend_car_reg   <= pend_car_next;
            served_up_reg  <= srv_up_next;
            served_dn_reg  <= srv_dn_next;
            served_car_reg <= srv_car_next;
        end
    end

    assign cur_floor  = floor_reg;
    assign dir_up     = dir_reg;
    assign moving     = (state_reg == ST_MOVE);
    assign door_open  = (state_reg == ST_DOOR);
    assign served_up  = served_up_reg;
    assign served_dn  = served_dn_reg;
    assign served_car = served_car_reg;

endmodule
